// File: rtl/cfu_cmd_if.sv
// CPU <-> CFU command/response handshake bundle.
// The master side is the CPU; the slave side is cfu_cmd_ctrl.
interface cfu_cmd_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid,
        input  cmd_ready,
        output cmd_payload_function_id,
        output cmd_payload_inputs_0,
        output cmd_payload_inputs_1,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_payload_function_id,
        input  cmd_payload_inputs_0,
        input  cmd_payload_inputs_1,
        output rsp_valid,
        input  rsp_ready,
        output rsp_payload_outputs_0
    );
endinterface

// File: rtl/cfu_cmd_ctrl.sv
// CFU command controller: IDLE/EXEC/RESP sequencer with per-opcode latency.
// Define CFU_CMD_CTRL_B2B_EN to allow back-to-back commands from RESP.
module cfu_cmd_ctrl #(
    parameter int unsigned VACC_CYCLES = 4,
    parameter int unsigned MUL_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    cfu_cmd_if.slave    bus,
    output logic        dec_valid,
    output logic [9:0]  dec_function_id,
    output logic [31:0] dec_inputs_0,
    output logic [31:0] dec_inputs_1,
    input  logic [31:0] exec_result,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [31:0] rsp_q;
    logic        cmd_ready;
    logic        accept;
    logic        commit;
    logic        zero_rsp;

    function automatic logic [3:0] load_cnt(input logic [2:0] op);
        logic [3:0] v;
        v = 4'd0;
        case (op)
            3'd3:    v = 4'(VACC_CYCLES - 1);
            3'd4,
            3'd5:    v = 4'(MUL_CYCLES - 1);
            default: v = 4'd0;
        endcase
        return v;
    endfunction

    assign accept   = bus.cmd_valid & cmd_ready;
    assign commit   = (state_q == EXEC) && (cnt_q == 4'd0);
    // Opcodes 6/7 run through the decoder but return a zero response.
    assign zero_rsp = dec_function_id[2:1] == 2'b11;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_d = EXEC;
                    cnt_d   = load_cnt(bus.cmd_payload_function_id[2:0]);
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
`ifdef CFU_CMD_CTRL_B2B_EN
                cmd_ready = bus.rsp_ready;
`else
                cmd_ready = 1'b0;
`endif
                if (bus.rsp_ready) begin
                    if (bus.cmd_valid && cmd_ready) begin
                        state_d = EXEC;
                        cnt_d   = load_cnt(bus.cmd_payload_function_id[2:0]);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cnt_q           <= 4'd0;
            rsp_q           <= 32'h0;
            dec_function_id <= 10'h0;
            dec_inputs_0    <= 32'h0;
            dec_inputs_1    <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                dec_function_id <= bus.cmd_payload_function_id;
                dec_inputs_0    <= bus.cmd_payload_inputs_0;
                dec_inputs_1    <= bus.cmd_payload_inputs_1;
            end
            if (commit) begin
                rsp_q <= zero_rsp ? 32'h0 : exec_result;
            end
        end
    end

    // Suppressed while reset is held so an aborted command never commits.
    assign dec_valid                 = commit & reset_n;
    assign busy                      = state_q != IDLE;
    assign bus.cmd_ready             = cmd_ready;
    assign bus.rsp_valid             = state_q == RESP;
    assign bus.rsp_payload_outputs_0 = rsp_q;

endmodule

// File: tb/tb_cfu_cmd_ctrl.sv
// Directed self-checking bench for cfu_cmd_ctrl (default parameters).
// Cycle 0 is the acceptance cycle; response expected in cycle L+1.
module tb_cfu_cmd_ctrl;
    logic        clk;
    logic        reset_n;
    logic        dec_valid;
    logic [9:0]  dec_function_id;
    logic [31:0] dec_inputs_0;
    logic [31:0] dec_inputs_1;
    logic [31:0] exec_result;
    logic        busy;

    int tests;
    int errors;

    cfu_cmd_if bus ();

    cfu_cmd_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus),
        .dec_valid       (dec_valid),
        .dec_function_id (dec_function_id),
        .dec_inputs_0    (dec_inputs_0),
        .dec_inputs_1    (dec_inputs_1),
        .exec_result     (exec_result),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [9:0] fid, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res,
                           input int l, input logic [31:0] exp_rsp,
                           input bit hold, input int stall);
        int n;
        int pulses;
        int pcyc;
        int bad;
        bit seen;
        @(posedge clk); #1;
        bus.cmd_valid               = 1'b1;
        bus.cmd_payload_function_id = fid;
        bus.cmd_payload_inputs_0    = a;
        bus.cmd_payload_inputs_1    = b;
        bus.rsp_ready               = (stall == 0);
        exec_result                 = res;
        @(negedge clk);
        check("acc_rdy", {31'b0, bus.cmd_ready}, 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = hold;
        if (hold) begin
            bus.cmd_payload_function_id = 10'h3FF;
            bus.cmd_payload_inputs_0    = 32'hDEAD_BEEF;
            bus.cmd_payload_inputs_1    = 32'hCAFE_F00D;
        end
        n = 0; pulses = 0; pcyc = 0; bad = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.cmd_ready) bad++;
            if (dec_valid) begin
                pulses++;
                pcyc = n;
            end
            if (bus.rsp_valid) seen = 1;
        end
        bus.cmd_valid = 1'b0;
        check("latency", n, l + 1);
        check("dec_pulses", pulses, 1);
        check("dec_cycle", pcyc, l);
        check("busy_rdy", bad, 0);
        check("dec_fid", {22'b0, dec_function_id}, {22'b0, fid});
        check("dec_in0", dec_inputs_0, a);
        check("dec_in1", dec_inputs_1, b);
        check("rsp_data", bus.rsp_payload_outputs_0, exp_rsp);
        if (stall > 0) begin
            bad = 0;
            for (int k = 0; k < stall; k++) begin
                exec_result = ~exec_result;
                bus.cmd_valid = 1'b1;
                @(posedge clk);
                @(negedge clk);
                if (!bus.rsp_valid || bus.cmd_ready || dec_valid ||
                    bus.rsp_payload_outputs_0 !== exp_rsp)
                    bad++;
            end
            bus.cmd_valid = 1'b0;
            check("stall_hold", bad, 0);
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("rsp_once", {31'b0, bus.rsp_valid}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int pulses;
        int seen;
        tests = 0;
        errors = 0;
        reset_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_payload_function_id = 10'h0;
        bus.cmd_payload_inputs_0 = 32'h0;
        bus.cmd_payload_inputs_1 = 32'h0;
        bus.rsp_ready = 1'b1;
        exec_result = 32'h0;

        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rspv", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_decv", {31'b0, dec_valid}, 32'd0);
        check("rst_fid", {22'b0, dec_function_id}, 32'd0);
        check("rst_in0", dec_inputs_0, 32'd0);
        check("rst_rsp", bus.rsp_payload_outputs_0, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_rdy", {31'b0, bus.cmd_ready}, 32'd1);

        run_cmd(10'h012, 32'h5, 32'h0, 32'hABCD, 1, 32'hABCD, 0, 0);
        run_cmd(10'h00B, 32'h11, 32'h22, 32'h1234_5678, 4,
                32'h1234_5678, 1, 0);
        run_cmd(10'h03F, 32'h1, 32'h2, 32'hFFFF_FFFF, 1, 32'h0, 0, 0);
        run_cmd(10'h00E, 32'h3, 32'h4, 32'h5555_AAAA, 1, 32'h0, 0, 0);
        run_cmd(10'h02C, 32'h7, 32'h8, 32'h0000_0042, 2, 32'h42, 0, 0);
        run_cmd(10'h0FD, 32'h9, 32'hA, 32'h8000_0001, 2,
                32'h8000_0001, 1, 0);
        run_cmd(10'h0A0, 32'hB, 32'hC, 32'h0BAD_CAFE, 1,
                32'h0BAD_CAFE, 0, 10);

        // Reset on the second EXEC cycle of a 2-cycle vmul.
        pulses = 0;
        seen = 0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_payload_function_id = 10'h01C;
        bus.cmd_payload_inputs_0 = 32'h77;
        bus.cmd_payload_inputs_1 = 32'h88;
        exec_result = 32'h9999;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        pulses += int'(dec_valid);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        pulses += int'(dec_valid);
        seen += int'(bus.rsp_valid);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rx_rdy", {31'b0, bus.cmd_ready}, 32'd1);
        check("rx_fid", {22'b0, dec_function_id}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pulses += int'(dec_valid);
            seen += int'(bus.rsp_valid);
        end
        check("rx_decv", pulses, 0);
        check("rx_rspv", seen, 0);

        // Command offered while the previous response completes.
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_payload_function_id = 10'h001;
        exec_result = 32'h1111;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b2b_rspv", {31'b0, bus.rsp_valid}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_payload_function_id = 10'h00A;
        exec_result = 32'h2222;
`ifdef CFU_CMD_CTRL_B2B_EN
        check("b2b_rdy", {31'b0, bus.cmd_ready}, 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_busy", {31'b0, busy}, 32'd1);
`else
        check("b2b_rdy", {31'b0, bus.cmd_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_busy", {31'b0, busy}, 32'd0);
        check("b2b_idle", {31'b0, bus.cmd_ready}, 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
`endif
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        check("b2b_seen", seen, 1);
        check("b2b_data", bus.rsp_payload_outputs_0, 32'h2222);
        check("b2b_fid", {22'b0, dec_function_id}, 32'h00A);
        @(posedge clk); #1;
        check("b2b_done", {31'b0, bus.rsp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
